// File: rtl/arch_map_table.sv
// Architectural (retirement) register map table.
// Holds the committed logical-to-physical mapping and retires up to four
// destinations per cycle. It returns each displaced mapping to the free list.
// On recovery it streams the committed map four entries per beat.
module arch_map_table #(
  parameter int unsigned SIZE_LOGICAL      = 32,
  parameter int unsigned SIZE_LOGICAL_LOG  = 5,
  parameter int unsigned SIZE_PHYSICAL_LOG = 7,
  parameter int unsigned RECOVER_BEATS     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         commitValid0_i,
  input  logic                         commitValid1_i,
  input  logic                         commitValid2_i,
  input  logic                         commitValid3_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest0_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest1_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest2_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest3_i,
  input  logic                         recoverFlag_i,
  output logic                         freedValid0_o,
  output logic                         freedValid1_o,
  output logic                         freedValid2_o,
  output logic                         freedValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg3_o,
  output logic                         recoverBusy_o,
  output logic [SIZE_LOGICAL_LOG-1:0]  recoverIdx_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverReg3_o
);

  localparam int unsigned BeatW = SIZE_LOGICAL_LOG - 2;

  typedef logic [SIZE_LOGICAL_LOG-1:0]  log_t;
  typedef logic [SIZE_PHYSICAL_LOG-1:0] phy_t;
  typedef enum logic [0:0] {StIdle, StRecover} state_e;

  logic [3:0] commit_valid;
  log_t       commit_log [4];
  phy_t       commit_phy [4];

  assign commit_valid  = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
  assign commit_log[0] = commitLogDest0_i;
  assign commit_log[1] = commitLogDest1_i;
  assign commit_log[2] = commitLogDest2_i;
  assign commit_log[3] = commitLogDest3_i;
  assign commit_phy[0] = commitPhyDest0_i;
  assign commit_phy[1] = commitPhyDest1_i;
  assign commit_phy[2] = commitPhyDest2_i;
  assign commit_phy[3] = commitPhyDest3_i;

  phy_t       amt_q [SIZE_LOGICAL];
  phy_t       amt_d [SIZE_LOGICAL];
  phy_t       prev  [4];
  logic [3:0] freed_valid_q, freed_valid_d;
  phy_t       freed_reg_q [4];
  phy_t       freed_reg_d [4];
  state_e     state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic       busy;
  phy_t       recover_reg [4];

  // Commit: find each slot's displaced mapping and build the next map.
  always_comb begin
    amt_d         = amt_q;
    freed_valid_d = commit_valid;
    for (int j = 0; j < 4; j++) begin
      prev[j] = amt_q[commit_log[j]];
      // Forward from older slots in the same group; the youngest older match wins.
      for (int m = 0; m < 4; m++) begin
        if (m < j && commit_valid[m] && commit_log[m] == commit_log[j]) begin
          prev[j] = commit_phy[m];
        end
      end
      freed_reg_d[j] = commit_valid[j] ? prev[j] : '0;
    end
    // Apply slots oldest first so the youngest writer of an entry wins.
    for (int j = 0; j < 4; j++) begin
      if (commit_valid[j]) begin
        amt_d[commit_log[j]] = commit_phy[j];
      end
    end
  end

  // Recovery walk FSM: idle until flagged, then RECOVER_BEATS beats.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (recoverFlag_i) begin
          state_d = StRecover;
          beat_d  = '0;
        end
      end
      StRecover: begin
        if (beat_q == BeatW'(RECOVER_BEATS - 1)) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  // State registers; reset restores the identity map and aborts any walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE_LOGICAL; i++) begin
        amt_q[i] <= phy_t'(i);
      end
      freed_valid_q <= '0;
      for (int j = 0; j < 4; j++) begin
        freed_reg_q[j] <= '0;
      end
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      amt_q         <= amt_d;
      freed_valid_q <= freed_valid_d;
      freed_reg_q   <= freed_reg_d;
      state_q       <= state_d;
      beat_q        <= beat_d;
    end
  end

  // Walk outputs are combinational from the beat counter and the map.
  always_comb begin
    busy = (state_q == StRecover);
    for (int j = 0; j < 4; j++) begin
      recover_reg[j] = busy ? amt_q[{beat_q, 2'(j)}] : '0;
    end
  end

  assign recoverBusy_o = busy;
  assign recoverIdx_o  = busy ? {beat_q, 2'b00} : '0;
  assign recoverReg0_o = recover_reg[0];
  assign recoverReg1_o = recover_reg[1];
  assign recoverReg2_o = recover_reg[2];
  assign recoverReg3_o = recover_reg[3];

  assign freedValid0_o = freed_valid_q[0];
  assign freedValid1_o = freed_valid_q[1];
  assign freedValid2_o = freed_valid_q[2];
  assign freedValid3_o = freed_valid_q[3];
  assign freedReg0_o   = freed_reg_q[0];
  assign freedReg1_o   = freed_reg_q[1];
  assign freedReg2_o   = freed_reg_q[2];
  assign freedReg3_o   = freed_reg_q[3];

endmodule

// File: tb/tb_arch_map_table.sv
// Self-checking bench for arch_map_table: directed cases plus randomized
// commits checked against a sequential-retirement reference map.
module tb_arch_map_table;

  logic       clk;
  logic       reset;
  logic [3:0] cv;
  logic [4:0] cl [4];
  logic [6:0] cp [4];
  logic       flag;
  logic [3:0] fv;
  logic [6:0] fr [4];
  logic       busy;
  logic [4:0] idx;
  logic [6:0] rr [4];

  int compared;
  int mismatched;

  // Reference: committed map, retired one instruction at a time.
  int         amt_m [32];
  logic [6:0] exp_reg [4];

  arch_map_table dut (
    .clk              (clk),
    .reset            (reset),
    .commitValid0_i   (cv[0]),
    .commitValid1_i   (cv[1]),
    .commitValid2_i   (cv[2]),
    .commitValid3_i   (cv[3]),
    .commitLogDest0_i (cl[0]),
    .commitLogDest1_i (cl[1]),
    .commitLogDest2_i (cl[2]),
    .commitLogDest3_i (cl[3]),
    .commitPhyDest0_i (cp[0]),
    .commitPhyDest1_i (cp[1]),
    .commitPhyDest2_i (cp[2]),
    .commitPhyDest3_i (cp[3]),
    .recoverFlag_i    (flag),
    .freedValid0_o    (fv[0]),
    .freedValid1_o    (fv[1]),
    .freedValid2_o    (fv[2]),
    .freedValid3_o    (fv[3]),
    .freedReg0_o      (fr[0]),
    .freedReg1_o      (fr[1]),
    .freedReg2_o      (fr[2]),
    .freedReg3_o      (fr[3]),
    .recoverBusy_o    (busy),
    .recoverIdx_o     (idx),
    .recoverReg0_o    (rr[0]),
    .recoverReg1_o    (rr[1]),
    .recoverReg2_o    (rr[2]),
    .recoverReg3_o    (rr[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) amt_m[i] = i;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, 0);
    chk({tag, ".idx"}, {27'd0, idx}, 0);
    chk({tag, ".fv"}, {28'd0, fv}, 0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s.fr%0d", tag, j), {25'd0, fr[j]}, 0);
      chk($sformatf("%s.rr%0d", tag, j), {25'd0, rr[j]}, 0);
    end
  endtask

  // One cycle with commit valids v (cl/cp preset) and recovery flag f;
  // checks the freed outputs in the following cycle.
  task automatic cycle(input logic [3:0] v, input logic f);
    for (int j = 0; j < 4; j++) begin
      if (v[j]) begin
        exp_reg[j] = 7'(amt_m[cl[j]]);
        amt_m[cl[j]] = int'(cp[j]);
      end else begin
        exp_reg[j] = '0;
      end
    end
    cv   = v;
    flag = f;
    @(posedge clk);
    #1;
    cv   = '0;
    flag = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("freed_valid%0d", j), {31'd0, fv[j]}, {31'd0, v[j]});
      chk($sformatf("freed_reg%0d", j), {25'd0, fr[j]}, {25'd0, exp_reg[j]});
    end
  endtask

  // Checks the walk beats that follow a flag cycle. A second flag is raised
  // during beat flag_beat; reset is pulsed during beat reset_beat (-1 = none).
  task automatic walk(input int flag_beat, input int reset_beat);
    for (int k = 0; k < 8; k++) begin
      if (k == reset_beat) begin
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid_walk");
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_reset_busy", {31'd0, busy}, 0);
        return;
      end
      chk($sformatf("beat%0d.busy", k), {31'd0, busy}, 1);
      chk($sformatf("beat%0d.idx", k), {27'd0, idx}, 4 * k);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("beat%0d.reg%0d", k, j), {25'd0, rr[j]}, amt_m[4 * k + j]);
      end
      if (k > 0) chk($sformatf("beat%0d.fv", k), {28'd0, fv}, 0);
      if (k == flag_beat) flag = 1'b1;
      @(posedge clk);
      #1;
      flag = 1'b0;
    end
    chk("walk_end.busy", {31'd0, busy}, 0);
    chk("walk_end.idx", {27'd0, idx}, 0);
    chk("walk_end.reg0", {25'd0, rr[0]}, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cv         = '0;
    flag       = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cl[j] = '0;
      cp[j] = '0;
    end
    model_reset();
    reset = 1'b1;
    #2;
    chk_all_zero("reset");
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Identity walk after reset.
    cycle(4'b0000, 1'b1);
    walk(-1, -1);

    // Single commits to log 5 and their freed registers.
    cl[0] = 5'd5; cp[0] = 7'd40;
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    cp[0] = 7'd41;
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);

    // Same-group WAW on log 3 with sparse valids.
    cl[0] = 5'd3; cp[0] = 7'd50;
    cl[1] = 5'd3; cp[1] = 7'd99;
    cl[2] = 5'd3; cp[2] = 7'd51;
    cl[3] = 5'd3; cp[3] = 7'd98;
    cycle(4'b0101, 1'b0);

    // All four slots target log 7.
    for (int j = 0; j < 4; j++) begin
      cl[j] = 5'd7;
      cp[j] = 7'(60 + j);
    end
    cycle(4'b1111, 1'b0);

    // Sparse valid 4'b1010.
    cl[1] = 5'd1; cp[1] = 7'd70;
    cl[3] = 5'd2; cp[3] = 7'd71;
    cycle(4'b1010, 1'b0);

    // Commit in the flag cycle; second flag during beat 4 is ignored.
    cl[0] = 5'd9; cp[0] = 7'd80;
    cycle(4'b0001, 1'b1);
    walk(4, -1);
    cycle(4'b0000, 1'b0);
    chk("no_restart.busy", {31'd0, busy}, 0);

    // Async reset during beat 3, then an identity walk.
    cycle(4'b0000, 1'b1);
    walk(-1, 3);
    cycle(4'b0000, 1'b1);
    walk(-1, -1);

    // Randomized commits, narrow logical range half the time to force WAW.
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < 4; j++) begin
        cl[j] = (it % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        cp[j] = 7'($urandom_range(0, 127));
      end
      cycle(4'($urandom_range(0, 15)), 1'b0);
    end
    cycle(4'b0000, 1'b1);
    walk(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
